// File: rtl/game_state.sv
// Playfield state for the frame renderer: bird physics, scrolling tubes with
// LFSR-chosen gaps, collision detection and the per-bird crash/respawn FSM.
// All state advances on frame_tick, so outputs hold steady through active video.
module game_state #(
  parameter int SPEED          = 4,
  parameter int GRAVITY        = 1,
  parameter int MAX_FALL       = 12,
  parameter int FLAP_V         = 10,
  parameter int TUBE_SPACING   = 400,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             flap1,
  input  logic             flap2,
  output logic [2:0][10:0] tube_x,
  output logic [2:0][10:0] gap_y,
  output logic [10:0]      bird1_y,
  output logic [10:0]      bird2_y,
  output logic             pending,
  output logic             pending_bird,
  output logic             running
);

  // Geometry shared with the renderer
  localparam int SCREEN_H = 768;
  localparam int BIRD_H   = 50;

  localparam logic [10:0]        SCREEN_W   = 11'd1024;
  localparam logic [10:0]        Y_MAX      = 11'(SCREEN_H - BIRD_H);
  localparam logic signed [11:0] Y_MAX_S    = 12'(SCREEN_H - BIRD_H);
  localparam logic [11:0]        TUBE_W     = 12'd120;
  localparam logic [11:0]        GAP_H      = 12'd250;
  localparam logic [11:0]        BIRD_W     = 12'd40;
  localparam logic [11:0]        BIRD_BOT   = 12'(BIRD_H - 1);
  localparam logic [11:0]        BIRD1_X    = 12'd180;
  localparam logic [11:0]        BIRD2_X    = 12'd260;
  localparam logic [10:0]        RESPAWN_Y  = 11'd300;
  localparam logic [10:0]        GAP_BASE   = 11'd60;
  localparam logic [10:0]        GAP_RESET  = 11'd200;

  localparam logic [10:0]        SPEED_W    = 11'(SPEED);
  localparam logic [10:0]        SPACING_W  = 11'(TUBE_SPACING);
  localparam logic signed [8:0]  GRAV9      = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXF9      = 9'(MAX_FALL);
  localparam logic signed [7:0]  MAXF8      = 8'(MAX_FALL);
  localparam logic signed [7:0]  NEG_FLAP   = 8'(-FLAP_V);
  localparam logic [7:0]         RESP_LOAD  = 8'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t state, state_next;

  // Shared views of per-tube / per-bird registers
  logic [10:0] tx [3];
  logic [10:0] gy [3];
  logic [10:0] tx_dec [3];
  logic [2:0]  tube_wrap;
  logic [10:0] by [2];

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [8:0]  lfsr_off;
  logic [10:0] gap_new;

  // Crash bookkeeping; a queued crash always belongs to the bird not pending
  logic        queued;
  logic [7:0]  cnt;
  logic        pending_next, pending_bird_next, queued_next, running_next;
  logic [7:0]  cnt_next;

  logic        active, tick, expire, crash_q;
  logic [1:0]  hidden, hit, flap_in;

  assign active  = (state != IDLE);
  assign tick    = frame_tick & active;
  assign flap_in = {flap2, flap1};
  assign expire  = tick && (state == PENDING) && (cnt == 8'd1);
  assign crash_q = queued | hit[~pending_bird];

  // ------------------------------------------------------------------ FSM

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      pending_bird <= 1'b0;
      queued       <= 1'b0;
      cnt          <= 8'd0;
      running      <= 1'b0;
    end else begin
      state        <= state_next;
      pending      <= pending_next;
      pending_bird <= pending_bird_next;
      queued       <= queued_next;
      cnt          <= cnt_next;
      running      <= running_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (|hit) state_next = PENDING;
      PENDING: if (expire && !crash_q) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Crash/respawn status: bird 1 wins a simultaneous crash, the other is queued
  always_comb begin
    pending_next      = pending;
    pending_bird_next = pending_bird;
    queued_next       = queued;
    cnt_next          = cnt;
    running_next      = (state_next != IDLE);
    case (state)
      RUN: begin
        if (|hit) begin
          pending_next      = 1'b1;
          pending_bird_next = ~hit[0];
          queued_next       = &hit;
          cnt_next          = RESP_LOAD;
        end
      end
      PENDING: begin
        if (expire) begin
          queued_next = 1'b0;
          if (crash_q) begin
            pending_bird_next = ~pending_bird;
            cnt_next          = RESP_LOAD;
          end else begin
            pending_next = 1'b0;
            cnt_next     = 8'd0;
          end
        end else begin
          if (tick) cnt_next = cnt - 8'd1;
          if (hit[~pending_bird]) queued_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- tubes

  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign lfsr_off = lfsr[8:0];
  // Fold offsets 400..511 back by 256 so the gap stays inside 60..459
  assign gap_new  = GAP_BASE + ((lfsr_off >= 9'd400) ? {2'b00, lfsr_off - 9'd256}
                                                     : {2'b00, lfsr_off});

  // LFSR advances only when a tube respawns and consumes a gap value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (tick && (|tube_wrap)) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_tube
    localparam logic [10:0] X_RESET = 11'(1024 + TUBE_SPACING * gi);
    localparam int          PREV    = (gi + 2) % 3;

    logic [10:0] x_reg;
    logic [10:0] g_reg;

    assign tx[gi]        = x_reg;
    assign gy[gi]        = g_reg;
    assign tx_dec[gi]    = x_reg - SPEED_W;
    assign tube_wrap[gi] = (x_reg < SPEED_W);
    assign tube_x[gi]    = x_reg;
    assign gap_y[gi]     = g_reg;

    // Scroll left; a tube leaving the left edge re-enters behind its predecessor
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_reg <= X_RESET;
        g_reg <= GAP_RESET;
      end else if (tick) begin
        if (tube_wrap[gi]) begin
          x_reg <= tx_dec[PREV] + SPACING_W;
          g_reg <= gap_new;
        end else begin
          x_reg <= tx_dec[gi];
        end
      end
    end
  end

  // ---------------------------------------------------------------- birds

  for (genvar gi = 0; gi < 2; gi++) begin : g_bird
    localparam logic        IDX = 1'(gi);
    localparam logic [11:0] BX  = (gi == 0) ? BIRD1_X : BIRD2_X;

    logic [10:0]        y_reg;
    logic signed [7:0]  vel_reg;
    logic               latch_reg;
    logic               flap_eff;
    logic signed [8:0]  vel_inc;
    logic signed [7:0]  vel_calc;
    logic signed [11:0] y_sum;
    logic [10:0]        y_calc;
    logic               tube_hit;

    assign by[gi]     = y_reg;
    assign hidden[gi] = (pending && (pending_bird == IDX)) ||
                        (queued  && (pending_bird != IDX));
    assign flap_eff   = latch_reg | flap_in[gi];
    assign vel_inc    = {vel_reg[7], vel_reg} + GRAV9;
    assign vel_calc   = flap_eff ? NEG_FLAP : ((vel_inc > MAXF9) ? MAXF8 : vel_inc[7:0]);
    assign y_sum      = {1'b0, y_reg} + {{4{vel_calc[7]}}, vel_calc};
    assign y_calc     = (y_sum < 12'sd0) ? 11'd0 :
                        ((y_sum > Y_MAX_S) ? Y_MAX : y_sum[10:0]);

    // Overlap with any on-screen tube outside its gap
    always_comb begin
      tube_hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if ((tx[i] < SCREEN_W) &&
            (BX + BIRD_W > {1'b0, tx[i]}) &&
            (BX < {1'b0, tx[i]} + TUBE_W) &&
            (({1'b0, by[gi]} < {1'b0, gy[i]}) ||
             ({1'b0, by[gi]} + BIRD_BOT > {1'b0, gy[i]} + GAP_H))) begin
          tube_hit = 1'b1;
        end
      end
    end

    assign hit[gi] = active && !hidden[gi] && ((y_reg == Y_MAX) || tube_hit);

    // Flap latch plus per-frame physics; hidden birds stay frozen
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_reg     <= RESPAWN_Y;
        vel_reg   <= 8'sd0;
        latch_reg <= 1'b0;
      end else if (tick) begin
        latch_reg <= 1'b0;
        if (expire && (pending_bird == IDX)) begin
          y_reg   <= RESPAWN_Y;
          vel_reg <= 8'sd0;
        end else if (!hidden[gi]) begin
          y_reg   <= y_calc;
          vel_reg <= vel_calc;
        end
      end else if (flap_in[gi]) begin
        latch_reg <= 1'b1;
      end
    end
  end

  assign bird1_y = by[0];
  assign bird2_y = by[1];

endmodule

// File: tb/tb_game_state.sv
// Randomized frame-by-frame bench for game_state against a behavioural model
// that keeps crashed birds in an ordered queue.
module tb_game_state;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             frame_tick;
  logic             start;
  logic             flap1;
  logic             flap2;
  logic [2:0][10:0] tube_x;
  logic [2:0][10:0] gap_y;
  logic [10:0]      bird1_y;
  logic [10:0]      bird2_y;
  logic             pending;
  logic             pending_bird;
  logic             running;

  game_state dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .start        (start),
    .flap1        (flap1),
    .flap2        (flap2),
    .tube_x       (tube_x),
    .gap_y        (gap_y),
    .bird1_y      (bird1_y),
    .bird2_y      (bird2_y),
    .pending      (pending),
    .pending_bird (pending_bird),
    .running      (running)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model
  bit m_run;
  int m_y [2];
  int m_v [2];
  int m_tx [3];
  int m_gy [3];
  int m_lfsr;
  int crash_q [$];   // front = bird currently hidden, back = queued crash
  int frames_left;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int k);
    foreach (crash_q[j]) if (crash_q[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_hit(input int k);
    int bx;
    bx = (k == 0) ? 180 : 260;
    if (m_y[k] == 718) return 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (m_tx[i] < 1024 && bx + 40 > m_tx[i] && bx < m_tx[i] + 120 &&
          (m_y[k] < m_gy[i] || m_y[k] + 49 > m_gy[i] + 250))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_tx[i] = 1024 + 400 * i;
      m_gy[i] = 200;
    end
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 300;
      m_v[k] = 0;
    end
    m_lfsr = 16'hACE1;
    crash_q.delete();
    frames_left = 0;
  endtask

  task automatic model_tick(input bit f1, input bit f2);
    int  old_x [3];
    bit  wrapped;
    int  o;
    bit  fl [2];
    if (!m_run) return;
    fl[0] = f1;
    fl[1] = f2;
    for (int k = 0; k < 2; k++) begin
      if (in_q(k)) begin
        if (k == crash_q[0] && frames_left == 1) begin
          m_y[k] = 300;
          m_v[k] = 0;
        end
      end else begin
        m_v[k] = fl[k] ? -10 : ((m_v[k] + 1 > 12) ? 12 : m_v[k] + 1);
        m_y[k] = m_y[k] + m_v[k];
        if (m_y[k] < 0)   m_y[k] = 0;
        if (m_y[k] > 718) m_y[k] = 718;
      end
    end
    for (int i = 0; i < 3; i++) old_x[i] = m_tx[i];
    wrapped = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (old_x[i] < 4) begin
        m_tx[i] = old_x[(i + 2) % 3] - 4 + 400;
        o = m_lfsr % 512;
        if (o >= 400) o = o - 256;
        m_gy[i] = 60 + o;
        wrapped = 1'b1;
      end else begin
        m_tx[i] = old_x[i] - 4;
      end
    end
    if (wrapped)
      m_lfsr = (m_lfsr / 2) + 32768 * ((m_lfsr ^ (m_lfsr / 4) ^ (m_lfsr / 8) ^ (m_lfsr / 32)) % 2);
    if (crash_q.size() > 0) begin
      frames_left--;
      if (frames_left == 0) begin
        void'(crash_q.pop_front());
        if (crash_q.size() > 0) frames_left = 60;
      end
    end
  endtask

  task automatic model_collide();
    if (!m_run) return;
    for (int k = 0; k < 2; k++) begin
      if (!in_q(k) && model_hit(k)) begin
        crash_q.push_back(k);
        if (crash_q.size() == 1) frames_left = 60;
      end
    end
  endtask

  task automatic check_pos();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tube_x%0d", i), 32'(tube_x[i]), m_tx[i]);
      chk($sformatf("gap_y%0d", i), 32'(gap_y[i]), m_gy[i]);
    end
    chk("bird1_y", 32'(bird1_y), m_y[0]);
    chk("bird2_y", 32'(bird2_y), m_y[1]);
  endtask

  task automatic check_status();
    chk("pending", 32'(pending), (crash_q.size() > 0) ? 1 : 0);
    if (crash_q.size() > 0) chk("pending_bird", 32'(pending_bird), crash_q[0]);
    chk("running", 32'(running), m_run ? 1 : 0);
  endtask

  // One frame: optional flap (before or with the tick), tick, check t+1, check t+2
  task automatic frame(input bit f1, input bit f2, input bit same);
    if (!same && (f1 || f2)) begin
      flap1 = f1;
      flap2 = f2;
      @(posedge clk); #1;
      flap1 = 1'b0;
      flap2 = 1'b0;
    end
    frame_tick = 1'b1;
    if (same) begin
      flap1 = f1;
      flap2 = f2;
    end
    @(posedge clk); #1;
    frame_tick = 1'b0;
    flap1 = 1'b0;
    flap2 = 1'b0;
    model_tick(f1, f2);
    check_pos();
    check_status();
    @(posedge clk); #1;
    model_collide();
    check_status();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_run = 1'b1;
    chk("running_after_start", 32'(running), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_pos();
    check_status();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    frame_tick = 1'b0;
    start = 1'b0;
    flap1 = 1'b0;
    flap2 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_pos();
    check_status();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ticks in IDLE move nothing
    repeat (3) frame(1'b0, 1'b0, 1'b1);

    // Directed flap: five falling frames (y 315, vel 5) then a bird-1 flap
    do_start();
    repeat (5) frame(1'b0, 1'b0, 1'b1);
    frame(1'b1, 1'b0, 1'b0);
    chk("flap_bird1", 32'(bird1_y), 305);
    chk("flap_bird2", 32'(bird2_y), 321);

    // Main randomized run from a fresh reset
    do_reset();
    do_start();
    for (int n = 1; n <= 900; n++) begin
      bit f1, f2, same;
      if (n <= 150) begin
        f1 = 1'b0;
        f2 = 1'b0;
      end else begin
        f1 = (m_y[0] > 450) ? 1'($urandom % 2) : 1'($urandom % 10 == 0);
        f2 = 1'($urandom % 7 == 0);
      end
      same = 1'($urandom % 2);
      frame(f1, f2, same);
      if (n == 10) begin
        chk("fall10_bird1", 32'(bird1_y), 355);
        chk("fall10_bird2", 32'(bird2_y), 355);
      end
      if (n == 41) begin
        chk("floor_both_pending", 32'(pending), 1);
        chk("floor_both_first", 32'(pending_bird), 0);
      end
      if (n == 101) begin
        chk("queued_pending", 32'(pending), 1);
        chk("queued_second", 32'(pending_bird), 1);
      end
      if (n == 256) chk("tube0_at_zero", 32'(tube_x[0]), 0);
      if (n == 257) begin
        chk("tube0_wrap", 32'(tube_x[0]), 1196);
        chk("gap0_range", 32'((gap_y[0] >= 60) && (gap_y[0] <= 459)), 1);
      end
    end

    // Reset while a bird is hidden
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      frame(1'b0, 1'($urandom % 5 == 0), 1'b1);
      if (crash_q.size() > 0) found = 1'b1;
    end
    chk("pending_reached", 32'(found), 1);
    do_reset();

    // Restart after reset
    do_start();
    repeat (20) frame(1'($urandom % 4 == 0), 1'($urandom % 4 == 0), 1'($urandom % 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
